// File: rtl/key_debounce_bank_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key debounce bank: the per-channel FSM state
// type, the board clock frequency, a millisecond-to-cycles helper and the
// default timing constants derived from it.
// ---------------------------------------------------------------------------
package key_pkg;

   // Per-key conditioner states
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_FILT = 2'd1,
      HELD       = 2'd2,
      REL_FILT   = 2'd3
   } key_state_t;

   localparam int CLK_FREQ_HZ   = 50_000_000;
   localparam int CYCLES_PER_MS = CLK_FREQ_HZ / 1000;

   function automatic int msToCycles(input int ms);
      return CYCLES_PER_MS * ms;
   endfunction

   localparam int DEF_DEBOUNCE_CYCLES      = msToCycles(20);
   localparam int DEF_REPEAT_DELAY_CYCLES  = msToCycles(500);
   localparam int DEF_REPEAT_PERIOD_CYCLES = msToCycles(100);

endpackage

// File: rtl/key_debounce_bank_if.sv
// ---------------------------------------------------------------------------
// key_debounce_bank_if
// Groups the raw key inputs and the conditioned pulse/level outputs of the
// debounce bank.
//   key_raw   : raw bouncing key levels (driven by the board / master)
//   key_pulse : one-cycle press / auto-repeat pulses (driven by the bank)
//   key_level : debounced pressed level, 1 = held (driven by the bank)
// ---------------------------------------------------------------------------
interface key_debounce_bank_if #(
   parameter int N_KEYS = 5
);
   logic [N_KEYS-1:0] key_raw;
   logic [N_KEYS-1:0] key_pulse;
   logic [N_KEYS-1:0] key_level;

   modport master (output key_raw, input key_pulse, input key_level);
   modport slave  (input key_raw, output key_pulse, output key_level);
endinterface

// File: rtl/key_debounce_bank_ch.sv
// ---------------------------------------------------------------------------
// key_debounce_ch
// One key channel: 2-flop synchroniser, debounce FSM with press and release
// filtering, and an optional auto-repeat counter.
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   i_key_raw   : raw asynchronous key level
//   o_key_pulse : registered one-cycle press / repeat pulse
//   o_key_level : registered debounced pressed level
// ---------------------------------------------------------------------------
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
   parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
   parameter bit REPEAT_ON            = 1'b0,
   parameter bit KEY_ACTIVE_LOW       = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_key_raw,
   output logic o_key_pulse,
   output logic o_key_level
);

   localparam int DEB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
   localparam int REP_W   = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;

   localparam logic [DEB_W-1:0] DEB_LAST       = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [REP_W-1:0] REP_PER_LAST   = REP_W'(REPEAT_PERIOD_CYCLES - 1);
   localparam logic             KEY_IDLE_LVL   = KEY_ACTIVE_LOW;

   logic             r_sync1;
   logic             r_sync2;
   key_state_t       r_state;
   logic [DEB_W-1:0] r_deb_cnt;
   logic [REP_W-1:0] r_rep_cnt;
   logic             r_rep_phase;
   logic             r_pulse;
   logic             r_level;
   logic             w_pressed;
   logic [REP_W-1:0] w_rep_limit;

   // Synchroniser loads the idle key level in reset so that releasing reset
   // with no key pressed can never look like a press edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= KEY_IDLE_LVL;
         r_sync2 <= KEY_IDLE_LVL;
      end else begin
         r_sync1 <= i_key_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_pressed   = KEY_ACTIVE_LOW ? ~r_sync2 : r_sync2;
   // Before the first repeat the counter runs to the long delay; once the
   // first repeat has fired it reloads and runs to the shorter period.
   assign w_rep_limit = r_rep_phase ? REP_PER_LAST : REP_DELAY_LAST;

   // Debounce / repeat FSM. deb_cnt counts consecutive stable samples
   // including the one that caused the state change, so acceptance happens
   // DEBOUNCE_CYCLES samples after the first stable one in both directions.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_deb_cnt   <= '0;
         r_rep_cnt   <= '0;
         r_rep_phase <= 1'b0;
         r_pulse     <= 1'b0;
         r_level     <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pressed) begin
                  r_state   <= PRESS_FILT;
                  r_deb_cnt <= DEB_W'(1);
               end else begin
                  r_deb_cnt <= '0;
               end
            end
            PRESS_FILT: begin
               if (!w_pressed) begin
                  r_state   <= IDLE;
                  r_deb_cnt <= '0;
               end else if (r_deb_cnt == DEB_LAST) begin
                  r_state     <= HELD;
                  r_deb_cnt   <= '0;
                  r_pulse     <= 1'b1;
                  r_level     <= 1'b1;
                  r_rep_cnt   <= '0;
                  r_rep_phase <= 1'b0;
               end else begin
                  r_deb_cnt <= r_deb_cnt + 1'b1;
               end
            end
            HELD: begin
               if (!w_pressed) begin
                  r_state   <= REL_FILT;
                  r_deb_cnt <= DEB_W'(1);
               end else if (REPEAT_ON) begin
                  if (r_rep_cnt == w_rep_limit) begin
                     r_pulse     <= 1'b1;
                     r_rep_cnt   <= '0;
                     r_rep_phase <= 1'b1;
                  end else begin
                     r_rep_cnt <= r_rep_cnt + 1'b1;
                  end
               end
            end
            REL_FILT: begin
               // Repeat counter is left untouched here so a release bounce
               // resumes the repeat timing where it stopped.
               if (w_pressed) begin
                  r_state   <= HELD;
                  r_deb_cnt <= '0;
               end else if (r_deb_cnt == DEB_LAST) begin
                  r_state   <= IDLE;
                  r_deb_cnt <= '0;
                  r_level   <= 1'b0;
               end else begin
                  r_deb_cnt <= r_deb_cnt + 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_deb_cnt <= '0;
            end
         endcase
      end
   end

   assign o_key_pulse = r_pulse;
   assign o_key_level = r_level;

endmodule

// File: rtl/key_debounce_bank.sv
// ---------------------------------------------------------------------------
// key_debounce_bank
// Bank of N_KEYS independent key conditioners feeding key_control. Each raw
// key becomes a one-cycle press pulse plus a debounced level; keys selected
// in REPEAT_EN also emit auto-repeat pulses while held.
//   clk     : system clock (50 MHz)
//   reset_n : asynchronous active-low reset
//   bus     : key_debounce_bank_if slave (key_raw in, key_pulse/key_level out)
// ---------------------------------------------------------------------------
module key_debounce_bank
   import key_pkg::*;
#(
   parameter int                N_KEYS               = 5,
   parameter int                DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
   parameter int                REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
   parameter int                REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
   parameter logic [N_KEYS-1:0] REPEAT_EN            = 5'b11100,
   parameter bit                KEY_ACTIVE_LOW       = 1'b1
) (
   input logic               clk,
   input logic               reset_n,
   key_debounce_bank_if.slave bus
);

   logic [N_KEYS-1:0] w_pulse;
   logic [N_KEYS-1:0] w_level;

   // One fully independent channel per key; no priority between keys.
   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
         .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
         .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
         .REPEAT_ON            (REPEAT_EN[g]),
         .KEY_ACTIVE_LOW       (KEY_ACTIVE_LOW)
      ) u_ch (
         .clk         (clk),
         .reset_n     (reset_n),
         .i_key_raw   (bus.key_raw[g]),
         .o_key_pulse (w_pulse[g]),
         .o_key_level (w_level[g])
      );
   end

   assign bus.key_pulse = w_pulse;
   assign bus.key_level = w_level;

endmodule

// File: tb/tb_key_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_bank
// Directed scenarios plus randomized bouncing keys, checked every cycle
// against a run-length based model of the key conditioner.
// ---------------------------------------------------------------------------
module tb_key_debounce_bank;

   localparam int          N_KEYS   = 5;
   localparam int          DEB      = 8;
   localparam int          RDLY     = 20;
   localparam int          RPER     = 6;
   localparam logic [4:0]  REP_EN   = 5'b11100;
   localparam bit          ACT_LOW  = 1'b1;

   logic clk;
   logic reset_n;
   int   cyc;
   int   checks;
   int   passes;

   key_debounce_bank_if #(.N_KEYS(N_KEYS)) keyIf ();

   key_debounce_bank #(
      .N_KEYS               (N_KEYS),
      .DEBOUNCE_CYCLES      (DEB),
      .REPEAT_DELAY_CYCLES  (RDLY),
      .REPEAT_PERIOD_CYCLES (RPER),
      .REPEAT_EN            (REP_EN),
      .KEY_ACTIVE_LOW       (ACT_LOW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (keyIf)
   );

   // 100 MHz-style clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time limit so a stuck run still terminates.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] time limit exceeded");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
   endtask

   // ---------------- behavioural model ----------------
   // A key is accepted as pressed once the synchronised input has read
   // "pressed" DEB samples in a row, and released after DEB "released"
   // samples in a row. Hold time accumulates on cycles the key is held and
   // was already held the cycle before; repeats fire at hold time RDLY,
   // RDLY+RPER, RDLY+2*RPER, ...
   logic [N_KEYS-1:0] md1, md2, mPulse, mLevel;
   int                runLen  [N_KEYS];
   logic              runVal  [N_KEYS];
   int                holdCnt [N_KEYS];
   logic              prevP   [N_KEYS];

   always @(posedge clk or negedge reset_n) begin
      logic p, lvl, pul;
      int   r, h;
      if (!reset_n) begin
         md1    <= '1;
         md2    <= '1;
         mPulse <= '0;
         mLevel <= '0;
         for (int k = 0; k < N_KEYS; k++) begin
            runLen[k]  <= 0;
            runVal[k]  <= 1'b0;
            holdCnt[k] <= 0;
            prevP[k]   <= 1'b0;
         end
      end else begin
         for (int k = 0; k < N_KEYS; k++) begin
            p   = ACT_LOW ? ~md2[k] : md2[k];
            r   = (p == runVal[k]) ? runLen[k] + 1 : 1;
            lvl = mLevel[k];
            pul = 1'b0;
            h   = holdCnt[k];
            if (!lvl) begin
               if (p && r == DEB) begin
                  lvl = 1'b1;
                  pul = 1'b1;
                  h   = 0;
               end
            end else if (!p && r == DEB) begin
               lvl = 1'b0;
            end else if (p && prevP[k]) begin
               h = h + 1;
               if (REP_EN[k] && h >= RDLY && ((h - RDLY) % RPER) == 0) pul = 1'b1;
            end
            runLen[k]  <= r;
            runVal[k]  <= p;
            holdCnt[k] <= h;
            prevP[k]   <= p;
            mLevel[k]  <= lvl;
            mPulse[k]  <= pul;
         end
         md1 <= keyIf.key_raw;
         md2 <= md1;
      end
   end

   // ---------------- per-cycle compare + pulse log ----------------
   int pulseKey[$];
   int pulseCyc[$];

   always @(posedge clk) begin
      cyc++;
      #1;
      for (int k = 0; k < N_KEYS; k++)
         if (keyIf.key_pulse[k]) begin
            pulseKey.push_back(k);
            pulseCyc.push_back(cyc);
         end
      checkOutput("cyc_pulse", int'(keyIf.key_pulse), int'(mPulse));
      checkOutput("cyc_level", int'(keyIf.key_level), int'(mLevel));
   end

   function automatic int countPulses(input int k, input int lo, input int hi);
      int n = 0;
      foreach (pulseKey[i])
         if (pulseKey[i] == k && pulseCyc[i] >= lo && pulseCyc[i] <= hi) n++;
      return n;
   endfunction

   function automatic int nthPulse(input int k, input int lo, input int hi, input int n);
      int seen = 0;
      foreach (pulseKey[i])
         if (pulseKey[i] == k && pulseCyc[i] >= lo && pulseCyc[i] <= hi) begin
            if (seen == n) return pulseCyc[i];
            seen++;
         end
      return -1;
   endfunction

   task automatic waitUntil(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic applyStimulus(input int k, input logic v, input int cycles);
      keyIf.key_raw[k] = v;
      repeat (cycles) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t, tl, tr, t2;
      int holdLeft [N_KEYS];
      int expOff [8];
      cyc     = 0;
      checks  = 0;
      passes  = 0;
      keyIf.key_raw = '1;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_pulse", int'(keyIf.key_pulse), 0);
      checkOutput("reset_level", int'(keyIf.key_level), 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // 1: clean press on key 0, no repeat
      t = cyc;
      keyIf.key_raw[0] = 1'b0;
      waitUntil(t + 9);
      checkOutput("t1_level_early", int'(keyIf.key_level[0]), 0);
      waitUntil(t + 10);
      checkOutput("t1_level_on", int'(keyIf.key_level[0]), 1);
      waitUntil(t + 40);
      keyIf.key_raw[0] = 1'b1;
      waitUntil(t + 70);
      checkOutput("t1_pulse_count", countPulses(0, t, t + 70), 1);
      checkOutput("t1_pulse_cycle", nthPulse(0, t, t + 70, 0), t + 10);

      // 2: bouncing press on key 1
      t = cyc;
      for (int k = 0; k < 10; k++) applyStimulus(1, logic'(k % 2), 3);
      tl = cyc;
      keyIf.key_raw[1] = 1'b0;
      waitUntil(tl + 40);
      keyIf.key_raw[1] = 1'b1;
      waitUntil(tl + 60);
      checkOutput("t2_pulse_count", countPulses(1, t, tl + 60), 1);
      checkOutput("t2_pulse_cycle", nthPulse(1, t, tl + 60, 0), tl + 10);

      // 3: short glitch on key 3
      t = cyc;
      applyStimulus(3, 1'b0, 5);
      applyStimulus(3, 1'b1, 20);
      checkOutput("t3_pulse_count", countPulses(3, t, cyc), 0);
      checkOutput("t3_level", int'(keyIf.key_level[3]), 0);

      // 4: auto-repeat on key 2, held 60 cycles after the press pulse
      t = cyc;
      keyIf.key_raw[2] = 1'b0;
      waitUntil(t + 68);
      keyIf.key_raw[2] = 1'b1;
      waitUntil(t + 100);
      expOff = '{0, 20, 26, 32, 38, 44, 50, 56};
      checkOutput("t4_pulse_count", countPulses(2, t, t + 100), 8);
      for (int n = 0; n < 8; n++)
         checkOutput($sformatf("t4_pulse%0d", n), nthPulse(2, t, t + 100, n), t + 10 + expOff[n]);

      // 5: release bounce then final release on key 4
      t = cyc;
      keyIf.key_raw[4] = 1'b0;
      waitUntil(t + 12);
      keyIf.key_raw[4] = 1'b1;
      waitUntil(t + 16);
      keyIf.key_raw[4] = 1'b0;
      waitUntil(t + 20);
      checkOutput("t5_level_bounce", int'(keyIf.key_level[4]), 1);
      waitUntil(t + 22);
      tr = cyc;
      keyIf.key_raw[4] = 1'b1;
      waitUntil(tr + 9);
      checkOutput("t5_level_hold", int'(keyIf.key_level[4]), 1);
      waitUntil(tr + 10);
      checkOutput("t5_level_off", int'(keyIf.key_level[4]), 0);
      waitUntil(tr + 30);
      checkOutput("t5_pulse_count", countPulses(4, t, tr + 30), 1);

      // 6: reset in the middle of the key 0 press filter (key 2 held)
      t2 = cyc;
      keyIf.key_raw[2] = 1'b0;
      waitUntil(t2 + 12);
      t = cyc;
      keyIf.key_raw[0] = 1'b0;
      waitUntil(t + 7);
      checkOutput("t6_level_before", int'(keyIf.key_level), 5'b00100);
      reset_n = 1'b0;
      #1;
      checkOutput("t6_pulse_in_reset", int'(keyIf.key_pulse), 0);
      checkOutput("t6_level_in_reset", int'(keyIf.key_level), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      tr = cyc;
      waitUntil(tr + 30);
      checkOutput("t6_pulse_count", countPulses(0, t, tr + 30), 1);
      checkOutput("t6_pulse_cycle", nthPulse(0, t, tr + 30, 0), tr + 10);
      keyIf.key_raw = '1;
      repeat (30) @(negedge clk);

      // Randomized bouncing on all keys with occasional resets
      for (int k = 0; k < N_KEYS; k++) holdLeft[k] = $urandom_range(1, 20);
      for (int c = 0; c < 2500; c++) begin
         for (int k = 0; k < N_KEYS; k++) begin
            if (holdLeft[k] == 0) begin
               keyIf.key_raw[k] = ~keyIf.key_raw[k];
               if ($urandom_range(0, 3) == 0) holdLeft[k] = $urandom_range(30, 80);
               else                           holdLeft[k] = $urandom_range(1, 12);
            end else begin
               holdLeft[k]--;
            end
         end
         reset_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      reset_n = 1'b1;
      keyIf.key_raw = '1;
      repeat (40) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
